// File: rtl/regfile_apb_arbiter.sv
// regfile_apb_arbiter
//   Shares the APB slave port of one register file between NUM_REQ requesters.
//   Accepts one command at a time, chosen round-robin, runs the APB SETUP/ACCESS
//   sequence for it, and returns a one-cycle response to the requester that
//   issued it. If the slave holds pready low for TIMEOUT_CYC ACCESS cycles, the
//   transfer is aborted with an error response. TIMEOUT_CYC=0 disables the abort.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   req_valid_i       per-requester command valid
//   req_ready_o       per-requester accept strobe (one-hot or zero)
//   req_write_i       per-requester direction, 1=write
//   req_addr_i        packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata_i       packed write data, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid_o       one-cycle response pulse to the issuing requester
//   rsp_rdata_o       read data, 0 for writes, aborts and outside the pulse
//   rsp_err_o         pslverr or timeout abort, only during the pulse
//   busy_o            transfer in progress
//   paddr_o, psel_o, penable_o, pwrite_o, pwdata_o   APB master outputs
//   prdata_i, pready_i, pslverr_i                    APB slave returns
module regfile_apb_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      busy_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic [DATA_W-1:0]         prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     gnt_q, gnt_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                gnt_found;
    logic [IdxW-1:0]     gnt_idx;
    int unsigned         scan;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                timeout_hit;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (32'(rr_ptr_q) + 32'(k)) % NUM_REQ;
            if (!gnt_found && req_valid_i[scan[IdxW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IdxW-1:0];
            end
        end
    end

    // Mux the granted requester's command fields.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IdxW'(i) == gnt_idx) begin
                sel_write = req_write_i[i];
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Counter holds the number of pready=0 ACCESS cycles already elapsed.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        req_ready_o = '0;

        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    req_ready_o = NUM_REQ'(1) << gnt_idx;
                    state_d     = StSetup;
                    gnt_d       = gnt_idx;
                    paddr_d     = sel_addr;
                    pwrite_d    = sel_write;
                    pwdata_d    = sel_write ? sel_wdata : '0;
                    rr_ptr_d    = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = '0;
            end
            StAccess: begin
                // A ready in the limit cycle wins over the abort.
                if (pready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                    rsp_err_d   = pslverr_i;
                end else if (timeout_hit) begin
                    state_d     = StIdle;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign psel_o      = (state_q != StIdle);
    assign penable_o   = (state_q == StAccess);
    assign busy_o      = (state_q != StIdle);
    assign paddr_o     = paddr_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_regfile_apb_arbiter.sv
// Self-checking bench for regfile_apb_arbiter (2 requesters, 8-bit address,
// 32-bit data, 16-cycle timeout). A small reference model tracks the
// round-robin pointer and the expected response of each transfer.
module tb_regfile_apb_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    regfile_apb_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .paddr_o     (paddr),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int           rr = 0;
    logic [N-1:0] exp_valid = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic         exp_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int g;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
        end
        return g;
    endfunction

    task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic scramble();
        req_valid = N'($urandom);
        req_write = N'($urandom);
        req_addr  = (N*AW)'($urandom);
        for (int i = 0; i < N; i++) req_wdata[i*DW +: DW] = $urandom;
    endtask

    // Compare response outputs with the model's pending response, then retire it.
    task automatic chk_rsp();
        chk("rsp_valid", rsp_valid, exp_valid);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, exp_err);
        exp_valid = '0;
        exp_rdata = '0;
        exp_err   = 1'b0;
    endtask

    // One IDLE cycle with no request expected to be accepted.
    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_noready", req_ready, '0);
        chk("idle_psel", psel, 0);
        chk("idle_busy", busy, 0);
        chk_rsp();
        @(posedge clk); #1;
    endtask

    // Full transfer starting in an IDLE cycle whose request inputs are already set.
    // waits = number of pready=0 ACCESS cycles before pready=1.
    task automatic xfer(input int waits, input logic [DW-1:0] rd, input logic serr);
        int            g;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_wd;
        logic [N-1:0]  onehot;
        logic          done;
        g      = model_grant();
        w      = req_write[g];
        a      = req_addr[g*AW +: AW];
        d      = req_wdata[g*DW +: DW];
        exp_wd = w ? d : '0;
        onehot = N'(1) << g;
        @(negedge clk);
        chk("accept_ready", req_ready, onehot);
        chk("accept_psel", psel, 0);
        chk_rsp();
        rr = (g + 1) % N;
        @(posedge clk); #1;
        scramble();
        @(negedge clk);
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, w);
        chk("setup_pwdata", pwdata, exp_wd);
        chk("setup_ready", req_ready, '0);
        chk("setup_busy", busy, 1);
        chk("setup_rsp", rsp_valid, '0);
        done = 1'b0;
        for (int n = 0; n < TO; n++) begin
            @(posedge clk); #1;
            scramble();
            pready  = (n == waits);
            prdata  = (n == waits) ? rd : $urandom;
            pslverr = (n == waits) ? serr : 1'($urandom);
            @(negedge clk);
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_paddr", paddr, a);
            chk("access_pwdata", pwdata, exp_wd);
            chk("access_rsp", rsp_valid, '0);
            if (n == waits) begin
                done = 1'b1;
                break;
            end
        end
        exp_valid = onehot;
        exp_rdata = (done && !w) ? rd : '0;
        exp_err   = done ? serr : 1'b1;
        @(posedge clk); #1;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = $urandom;
        req_valid = '0;
    endtask

    // Reset asserted during the first ACCESS cycle of a transfer from requester g.
    task automatic reset_mid(input int g);
        req_valid = '0;
        set_req(g, 1'b1, 1'b0, 8'h0C, 32'h0);
        @(negedge clk);
        chk("rm_ready", req_ready, N'(1) << g);
        chk_rsp();
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_penable", penable, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_psel_async", psel, 0);
        chk("rm_penable_async", penable, 0);
        chk("rm_busy_async", busy, 0);
        chk("rm_rsp", rsp_valid, '0);
        rr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rm_rsp_after", rsp_valid, '0);
        @(posedge clk); #1;
        // Both valid: the reset pointer must pick requester 0.
        set_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
        set_req(1, 1'b1, 1'b0, 8'h14, 32'h0);
        @(negedge clk);
        chk("rm_first_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        rr = 1;
        @(posedge clk); #1;
        pready = 1'b1;
        prdata = 32'h0000_00A5;
        @(negedge clk);
        exp_valid = 2'b01;
        exp_rdata = 32'h0000_00A5;
        exp_err   = 1'b0;
        @(posedge clk); #1;
        pready = 1'b0;
        idle_cycle();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state.
        #12;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycle();

        // Single write from requester 0.
        set_req(0, 1'b1, 1'b1, 8'h0C, 32'h1234_5678);
        xfer(0, 32'hFFFF_FFFF, 1'b0);
        idle_cycle();

        // Both requesters streaming reads, back to back.
        for (int t = 0; t < 6; t++) begin
            set_req(0, 1'b1, 1'b0, AW'(8'h20 + t), 32'h0);
            set_req(1, 1'b1, 1'b0, AW'(8'h40 + t), 32'h0);
            xfer(0, $urandom, 1'b0);
        end
        idle_cycle();

        // Read with three wait states.
        set_req(1, 1'b1, 1'b0, 8'h0C, 32'h0);
        xfer(3, 32'hDEAD_BEEF, 1'b0);
        idle_cycle();

        // Write with slave error.
        set_req(0, 1'b1, 1'b1, 8'h04, 32'hCAFE_0001);
        xfer(0, 32'h5555_5555, 1'b1);
        idle_cycle();

        // Stuck slave: timeout abort, then a normal transfer.
        set_req(0, 1'b1, 1'b0, 8'h08, 32'h0);
        xfer(100, 32'h0, 1'b0);
        set_req(1, 1'b1, 1'b1, 8'h18, 32'h0BAD_F00D);
        xfer(0, 32'h0, 1'b0);
        idle_cycle();

        // Ready arriving exactly in the last allowed ACCESS cycle completes normally.
        set_req(1, 1'b1, 1'b0, 8'h1C, 32'h0);
        xfer(TO - 1, 32'h7777_0001, 1'b0);
        idle_cycle();

        // Reset in mid transfer, from each requester.
        reset_mid(1);
        reset_mid(0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            req_valid = N'($urandom_range(1, 3));
            req_write = N'($urandom);
            req_addr  = (N*AW)'($urandom);
            for (int i = 0; i < N; i++) req_wdata[i*DW +: DW] = $urandom;
            xfer(($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3), $urandom,
                 ($urandom_range(0, 3) == 0));
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
